// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: FSM states, write-mask constants and byte merge shared by the SRAM arbiter
package sram_arb_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4,
        RECOVER   = 3'd5
    } state_t;
    localparam logic [1:0] WMASK_FULL = 2'b11;
    localparam logic [1:0] WMASK_NONE = 2'b00;
    function automatic logic [15:0] merge_bytes(input logic [15:0] wdata, input logic [15:0] rdata, input logic [1:0] mask);
        return {mask[1] ? wdata[15:8] : rdata[15:8], mask[0] ? wdata[7:0] : rdata[7:0]};
    endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes plus the asram wrapper strobe/data bus
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
);
    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic                  p0_ack;
    logic                  p0_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic                  p1_req;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic                  p1_we;
    logic [1:0]            p1_wmask;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_ack;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  mem_read_n;
    logic                  mem_write_n;
    logic                  mem_ce_n;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;
    modport slave (
        input  p0_req, p0_addr, p1_req, p1_addr, p1_we, p1_wmask, p1_wdata, mem_rdata,
        output p0_ack, p0_rvalid, p0_rdata, p1_ack, p1_rvalid, p1_rdata,
               mem_read_n, mem_write_n, mem_ce_n, mem_addr, mem_wdata, busy
    );
    modport master (
        output p0_req, p0_addr, p1_req, p1_addr, p1_we, p1_wmask, p1_wdata, mem_rdata,
        input  p0_ack, p0_rvalid, p0_rdata, p1_ack, p1_rvalid, p1_rdata,
               mem_read_n, mem_write_n, mem_ce_n, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/sram_arb_select.sv
// sram_arb_select: port-0-first grant decision with a saturating port-1 starvation counter
module sram_arb_select #(
    parameter int MAX_P0_BURST = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic p0_req_i,
    input  logic p1_req_i,
    output logic grant_p0_o,
    output logic grant_p1_o
);
    localparam int CW = $clog2(MAX_P0_BURST + 1);
    logic [CW-1:0] starve_q, starve_d;
    // port 1 overrides port 0 once port 0 has used up its burst allowance
    always_comb begin
        grant_p1_o = idle_i && p1_req_i && (!p0_req_i || starve_q == CW'(MAX_P0_BURST));
        grant_p0_o = idle_i && p0_req_i && !grant_p1_o;
        starve_d   = (!p1_req_i || grant_p1_o) ? '0 :
                     (grant_p0_o && starve_q < CW'(MAX_P0_BURST)) ? starve_q + 1'b1 : starve_q;
    end
    // starvation counter register
    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the async SRAM between a scan reader and a byte-masked SPI write path
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 18,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_WAIT    = 3,
    parameter int WRITE_WAIT   = 1,
    parameter int MAX_P0_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int CW = $clog2((READ_WAIT > WRITE_WAIT ? READ_WAIT : WRITE_WAIT) + 2);
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_rd, last_wr, grant_p0, grant_p1;
    logic                  owner_q, p0_rvalid_q, p1_rvalid_q;
    logic [1:0]            mask_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, mem_wdata_q, p0_rdata_q, p1_rdata_q;

    sram_arb_select #(.MAX_P0_BURST(MAX_P0_BURST)) u_select (
        .clk        (clk),
        .rst        (rst),
        .idle_i     (state_q == IDLE && !rst),
        .p0_req_i   (bus.p0_req),
        .p1_req_i   (bus.p1_req),
        .grant_p0_o (grant_p0),
        .grant_p1_o (grant_p1)
    );

    // next state; the phase counter restarts whenever the state changes
    always_comb begin
        last_rd = cnt_q == CW'(READ_WAIT);
        last_wr = cnt_q == CW'(WRITE_WAIT);
        state_d = state_q;
        case (state_q)
            IDLE:             state_d = grant_p0 ? READ :
                                        !grant_p1 ? IDLE :
                                        !bus.p1_we ? READ :
                                        bus.p1_wmask == WMASK_FULL ? WRITE :
                                        bus.p1_wmask == WMASK_NONE ? RECOVER : RMW_READ;
            READ:             state_d = last_rd ? RECOVER : READ;
            RMW_READ:         state_d = last_rd ? RMW_WRITE : RMW_READ;
            WRITE, RMW_WRITE: state_d = last_wr ? RECOVER : state_q;
            default:          state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // state, latched request fields, captured read data and rvalid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            mask_q      <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p0_rvalid_q <= state_q == READ && last_rd && !owner_q;
            p1_rvalid_q <= state_q == READ && last_rd && owner_q;
            if (grant_p0 || grant_p1) begin
                owner_q    <= grant_p1;
                mem_addr_q <= grant_p1 ? bus.p1_addr : bus.p0_addr;
            end
            if (grant_p1) begin
                mask_q  <= bus.p1_wmask;
                wdata_q <= bus.p1_wdata;
            end
            if (grant_p1 && bus.p1_we && bus.p1_wmask == WMASK_FULL) mem_wdata_q <= bus.p1_wdata;
            if (state_q == READ && last_rd && !owner_q) p0_rdata_q <= bus.mem_rdata;
            if (state_q == READ && last_rd && owner_q) p1_rdata_q <= bus.mem_rdata;
            if (state_q == RMW_READ && last_rd) mem_wdata_q <= merge_bytes(wdata_q, bus.mem_rdata, mask_q);
        end
    end

    assign bus.p0_ack      = grant_p0;
    assign bus.p1_ack      = grant_p1;
    assign bus.p0_rvalid   = p0_rvalid_q;
    assign bus.p1_rvalid   = p1_rvalid_q;
    assign bus.p0_rdata    = p0_rdata_q;
    assign bus.p1_rdata    = p1_rdata_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_read_n  = !(state_q == READ || state_q == RMW_READ);
    assign bus.mem_write_n = !(state_q == WRITE || state_q == RMW_WRITE);
    assign bus.mem_ce_n    = bus.mem_read_n && bus.mem_write_n;
    assign bus.busy        = state_q != IDLE;
endmodule
